// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if -- signal bundle between a serial line source and the UART
// receiver.
//
//   rx          serial line, idle high (driven by the line side)
//   rx_data     last correctly received byte
//   rx_done     one-clk pulse when rx_data is updated
//   frame_err   one-clk pulse on a bad stop bit
//   parity_err  one-clk pulse on an even-parity mismatch
//   busy        receiver is somewhere inside a frame
//
// Modports:
//   master  line side / consumer: drives rx, observes the receiver outputs
//   slave   receiver side: samples rx, drives the outputs
// -----------------------------------------------------------------------------
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    output rx,
    input  rx_data, rx_done, frame_err, parity_err, busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_done, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 16x oversampling UART receiver, 8 data bits, LSB first, 1 stop.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz
//   BAUD    line bit rate
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_if.slave (rx in; rx_data, rx_done, frame_err,
//          parity_err, busy out)
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 8E1 framing, one even-parity bit checked
//                      undefined -> 8N1 framing, parity_err tied low
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  // Oversample divider: DIV = floor(CLK_HZ / (16 * BAUD)), never below 1.
  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rx_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [7:0]       data_q;
  logic             done_q;
  logic             ferr_q;
  logic             shift_en;
  logic             load_en;
  logic             ferr_set;
`ifdef UART_RX_PARITY_EN
  logic             par_cap;
  logic             par_bad;
  logic             perr_set;
  logic             perr_q;
`endif

  // Two-flop synchronizer; flops reset to the idle (high) line level so a
  // reset release never looks like a start edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
    end
  end

  // Free-running 16x tick generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    load_en    = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap    = 1'b0;
    perr_set   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (tick && !rx_sync) state_next = START;
      end
      START: begin
        // Mid-bit recheck; a line already back high was only a glitch.
        if (tick && tick_cnt == 4'd7) state_next = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (tick && tick_cnt == 4'd15) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_next = PARITY;
`else
          if (bit_cnt == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && tick_cnt == 4'd15) begin
          par_cap    = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && tick_cnt == 4'd15) begin
          // Framing error outranks both a parity error and a good byte.
          if (!rx_sync) begin
            ferr_set   = 1'b1;
            state_next = WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad) begin
            perr_set   = 1'b1;
            state_next = IDLE;
          end
`endif
          else begin
            load_en    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break must end before another start is looked for.
        if (rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      done_q <= load_en;
      ferr_q <= ferr_set;
`ifdef UART_RX_PARITY_EN
      perr_q <= perr_set;
      // Even parity: the parity bit must equal the XOR of the data bits.
      if (par_cap) par_bad <= rx_sync ^ (^shift);
`endif
      if (state_next != state) tick_cnt <= 4'd0;
      else if (tick)           tick_cnt <= tick_cnt + 4'd1;

      // Exactly eight shifts per frame, so bit_cnt wraps back to 0 by the
      // time DATA is left and needs no separate clear.
      if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {rx_sync, shift[7:1]};
      end
      if (load_en) data_q <= shift;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_done   = done_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at 50 MHz / 115200 baud.
// Frames are driven bit by bit; a frame-level model predicts the received
// bytes and error pulses, and a negedge monitor records what the receiver
// actually produced. Honours UART_RX_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115_200;
  localparam int DIV    = (CLK_HZ / (BAUD * 16) < 1) ? 1 : CLK_HZ / (BAUD * 16);
  localparam int BIT    = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  uart_rx_if bus ();

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  // Observed behaviour.
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         overlap_cnt = 0;
  int         wide_cnt = 0;
  longint     last_done_cyc = 0;
  logic [7:0] got_q[$];
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_perr = 1'b0;

  // Reference model state.
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int         exp_ferr = 0;
  int         exp_perr = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rx_done) begin
      done_cnt++;
      got_q.push_back(bus.rx_data);
      last_done_cyc = cyc;
    end
    if (bus.frame_err)  ferr_cnt++;
    if (bus.parity_err) perr_cnt++;
    if ((bus.rx_done && bus.frame_err) || (bus.rx_done && bus.parity_err) ||
        (bus.frame_err && bus.parity_err))
      overlap_cnt++;
    if ((bus.rx_done && prev_done) || (bus.frame_err && prev_ferr) ||
        (bus.parity_err && prev_perr))
      wide_cnt++;
    prev_done = bus.rx_done;
    prev_ferr = bus.frame_err;
    prev_perr = bus.parity_err;
  end

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within its cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-level outcome: a low stop bit is a framing error, otherwise a bad
  // parity bit is a parity error, otherwise the byte is delivered.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    if (!stop_ok)                exp_ferr++;
    else if (PAR_EN && !par_ok)  exp_perr++;
    else begin
      exp_q.push_back(d);
      exp_data = d;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                            input int stop_bits);
    logic even_bit;
    even_bit = ($countones(d) % 2) == 1;
    bus.rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_clks(BIT);
    end
    if (PAR_EN) begin
      bus.rx = par_ok ? even_bit : ~even_bit;
      wait_clks(BIT);
    end
    bus.rx = stop_ok;
    wait_clks(BIT * stop_bits);
    bus.rx = 1'b1;
    model_frame(d, stop_ok, par_ok);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_done_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(exp_data));
    check({tag, "_frame_err_count"}, 32'(ferr_cnt), 32'(exp_ferr));
    check({tag, "_parity_err_count"}, 32'(perr_cnt), 32'(exp_perr));
  endtask

  initial begin
    longint     start_cyc;
    int         lat;
    bit         saw_busy;
    logic [7:0] d;
    logic [7:0] pat;
    bit         stop_ok;
    int         gap;

    // Reset state.
    bus.rx = 1'b1;
    rst_n  = 1'b0;
    wait_clks(5);
    check("reset_rx_data", 32'(bus.rx_data), 32'h00);
    check("reset_rx_done", 32'(bus.rx_done), 32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_parity_err", 32'(bus.parity_err), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    wait_clks(BIT);

    // 0xA5: one pulse, about 9.5 bit times after the start edge.
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    lat = int'(last_done_cyc - start_cyc);
    check("a5_latency_in_window",
          32'((lat >= (BIT * 94) / 10) && (lat <= (BIT * 97) / 10)), 32'h1);
    wait_clks(BIT);
    compare_all("a5");

    // Glitch of three ticks: rejected silently, busy drops before count 8.
    saw_busy = 1'b0;
    bus.rx = 1'b0;
    for (int i = 0; i < 3 * DIV; i++) begin
      wait_clks(1);
      if (bus.busy) saw_busy = 1'b1;
    end
    bus.rx = 1'b1;
    for (int i = 0; i < 8 * DIV + 4 && bus.busy; i++) wait_clks(1);
    check("glitch_busy_seen", 32'(saw_busy), 32'h1);
    check("glitch_busy_cleared", 32'(bus.busy), 32'h0);
    wait_clks(BIT);
    compare_all("glitch");

    // 0x3C with a low stop bit held two bit times, then a clean 0x11.
    send_frame(8'h3C, 1'b0, 1'b1, 2);
    wait_clks(BIT);
    compare_all("frame_err");
    send_frame(8'h11, 1'b1, 1'b1, 1);
    wait_clks(BIT);
    compare_all("after_frame_err");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1'b1, 1);
    wait_clks(BIT);
    compare_all("back_to_back");

    // Random bytes, occasional bad stop bit, random idle gaps.
    for (int n = 0; n < 4; n++) begin
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      gap     = stop_ok ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1));
      send_frame(d, stop_ok, 1'b1, 1);
      wait_clks(gap * BIT);
    end
    wait_clks(BIT);
    compare_all("random");

    // Reset in the middle of bit 4 of 0x5A aborts the frame.
    pat = 8'h5A;
    bus.rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      bus.rx = pat[i];
      wait_clks(BIT);
    end
    bus.rx = pat[4];
    wait_clks(BIT / 2);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_busy", 32'(bus.busy), 32'h0);
    check("midframe_reset_rx_data", 32'(bus.rx_data), 32'h00);
    exp_data = 8'h00;
    bus.rx = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(2 * BIT);
    compare_all("midframe_reset");
    send_frame(8'h81, 1'b1, 1'b1, 1);
    wait_clks(BIT);
    compare_all("after_reset");

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x3C has four ones, so a parity bit of 0 is correct.
    send_frame(8'h3C, 1'b1, 1'b1, 1);
    wait_clks(BIT);
    compare_all("parity_good");
    send_frame(8'h3C, 1'b1, 1'b0, 1);
    wait_clks(BIT);
    compare_all("parity_bad");
`endif

    check("pulse_overlap", 32'(overlap_cnt), 32'h0);
    check("pulse_width", 32'(wide_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200: line bit rate.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx  input  1: asynchronous serial line; idle high.
REQ-006 SHALL have port rx_data  output  8: last correctly received byte.
REQ-007 SHALL have port rx_done  output  1: one-clk pulse when rx_data is updated.
REQ-008 SHALL have port frame_err  output  1: one-clk pulse on bad stop bit.
REQ-009 SHALL have port parity_err  output  1: one-clk pulse on parity mismatch.
REQ-010 SHALL have port busy  output  1: high whenever the state is not IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; only the synchronized value is used.
REQ-012 SHALL generate a 16x oversample tick: divider counts 0..DIV-1 with DIV = CLK_HZ/(BAUD*16), integer floor, minimum 1; tick is a one-clk pulse at DIV-1; divider free-runs, wraps to 0.
REQ-013 SHALL use a 4-bit tick counter per bit period, wrapping 15->0; it clears on every state change.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-015 IDLE: on a tick with synced rx=0 -> START.
REQ-016 START: on tick count 7 (mid-bit), rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, no pulse).
REQ-017 DATA: sample at tick count 15 of each bit; shift LSB-first; after bit 8 -> PARITY (macro on) or STOP.
REQ-018 STOP: sample at tick count 15; rx=1 with no error -> load rx_data, pulse rx_done, go to IDLE; rx=0 -> pulse frame_err, go to WAIT_IDLE; rx_data unchanged.
REQ-019 WAIT_IDLE: stay until synced rx=1, then -> IDLE (a break does not retrigger).
REQ-020 rx_done and frame_err SHALL NOT both assert for one frame; frame_err has priority over rx_done and parity_err.
REQ-021 rx_data SHALL hold its value between frames; rx_done latency is 1 clk after the stop-bit sample.
REQ-022 A new start edge SHALL be accepted on the first tick after returning to IDLE, allowing back-to-back frames.

Reset
REQ-023 rst_n low SHALL immediately force: state IDLE, synchronizer flops 1, divider 0, tick counter 0, shift register 0, rx_data 0x00, rx_done 0, frame_err 0, parity_err 0, busy 0.
REQ-024 Reset mid-frame SHALL abort the frame with no output pulse; reception resumes at the next falling edge after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: SHALL insert the PARITY state and sample one even-parity bit at tick count 15.
REQ-026 With UART_RX_PARITY_EN, a mismatch SHALL pulse parity_err at stop-bit evaluation; rx_done does not pulse; rx_data is unchanged; the state goes to IDLE.
REQ-027 Macro UART_RX_PARITY_EN undefined: SHALL omit the PARITY state (8N1 framing) and tie parity_err to 0.

Verification
REQ-028 Send 0xA5 in 8N1 at CLK_HZ=50000000, BAUD=115200 (DIV=27) -> exactly one rx_done pulse, rx_data=0xA5, about 9.5 bit times after the start edge.
REQ-029 Drive rx low for 3 ticks, then high -> no rx_done, no frame_err; busy returns to 0 before count 8.
REQ-030 Send 0x3C with stop bit 0, holding the line low 2 bit times -> frame_err pulses once, rx_data keeps its prior value; next 0x11 frame -> rx_data=0x11.
REQ-031 Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_done pulses, values 0x00 then 0xFF.
REQ-032 Assert rst_n low during bit 4 of 0x5A, release, send 0x81 -> no pulse for 0x5A; rx_data=0x81 with one rx_done.
REQ-033 With UART_RX_PARITY_EN: 0x3C with parity 0 -> rx_done; same byte with parity 1 -> parity_err pulse only.
